// File: rtl/regset_pkg.sv
// Shared definitions for the register-set write arbiter: FSM encoding,
// register-index and data widths, default register count and a range helper.
package regset_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int REG_IDX_W     = 3;
  localparam int DATA_W        = 4;
  localparam int DEFAULT_NREGS = 6;

  function automatic logic addr_in_range(input logic [REG_IDX_W-1:0] addr,
                                         input int                   nregs);
    return int'(addr) < nregs;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first requesting index strictly after
// last_winner (wrapping), returned as a one-hot grant vector.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_winner,
  output logic [NREQ-1:0] gnt
);

  logic [IDXW-1:0] idx;
  logic            found;

  // NOTE: every variable written in always_comb is given a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDXW'((int'(last_winner) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regset_wr_arb.sv
// Multi-requester write arbiter feeding a small register set (WR/WRD/Reg_EN).
// Define REGSET_ARB_LOCK_EN to add the lock input and locked-burst state.
module regset_wr_arb
  import regset_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int MAXBURST = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*REG_IDX_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0]    req_data,
`ifdef REGSET_ARB_LOCK_EN
  input  logic [NREQ-1:0]           lock,
`endif
  output logic [NREQ-1:0]           gnt,
  output logic [REG_IDX_W-1:0]      WR,
  output logic [DATA_W-1:0]         WRD,
  output logic                      Reg_EN,
  output logic                      err
);

  localparam int IDXW = (NREQ > 2) ? 2 : 1;

  logic [IDXW-1:0]      last_winner;
  logic [NREQ-1:0]      rr_gnt;
  logic [IDXW-1:0]      rr_idx;
  logic                 acc;
  logic [IDXW-1:0]      acc_idx;
  logic [REG_IDX_W-1:0] acc_addr;
  logic [DATA_W-1:0]    acc_data;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req         (req),
    .last_winner (last_winner),
    .gnt         (rr_gnt)
  );

  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_gnt[i]) rr_idx = IDXW'(i);
    end
  end

`ifdef REGSET_ARB_LOCK_EN
  arb_state_e state, state_nxt;
  logic [2:0] burst_cnt, burst_nxt;
  logic       owner_hold;

  assign owner_hold = req[last_winner] & lock[last_winner];

  // The owner is always last_winner while locked; dropping req or lock ends
  // the burst with an idle cycle, and arbitration resumes on the next one.
  always_comb begin
    gnt       = '0;
    acc       = 1'b0;
    acc_idx   = rr_idx;
    state_nxt = state;
    burst_nxt = burst_cnt;
    if (!reset) begin
      unique case (state)
        ARB: begin
          if (|rr_gnt) begin
            gnt     = rr_gnt;
            acc     = 1'b1;
            acc_idx = rr_idx;
            if (lock[rr_idx] && MAXBURST > 1) begin
              state_nxt = LOCK;
              burst_nxt = 3'd1;
            end
          end
        end
        LOCK: begin
          if (owner_hold) begin
            gnt[last_winner] = 1'b1;
            acc              = 1'b1;
            acc_idx          = last_winner;
            if (int'(burst_cnt) + 1 >= MAXBURST) begin
              state_nxt = ARB;
              burst_nxt = 3'd0;
            end else begin
              burst_nxt = burst_cnt + 3'd1;
            end
          end else begin
            state_nxt = ARB;
            burst_nxt = 3'd0;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ARB;
      burst_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end
`else
  always_comb begin
    gnt     = reset ? '0 : rr_gnt;
    acc     = |gnt;
    acc_idx = rr_idx;
  end
`endif

  always_comb begin
    acc_addr = '0;
    acc_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_idx == IDXW'(i)) begin
        acc_addr = req_addr[i*REG_IDX_W +: REG_IDX_W];
        acc_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_winner <= IDXW'(NREQ - 1);
      WR          <= '0;
      WRD         <= '0;
      Reg_EN      <= 1'b0;
      err         <= 1'b0;
    end else begin
      Reg_EN <= 1'b0;
      err    <= 1'b0;
      if (acc) begin
        last_winner <= acc_idx;
        if (addr_in_range(acc_addr, NREGS)) begin
          WR     <= acc_addr;
          WRD    <= acc_data;
          Reg_EN <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regset_wr_arb.sv
// Scoreboard bench for regset_wr_arb (3 requesters, 6 registers, burst 4);
// lock scenarios are exercised when REGSET_ARB_LOCK_EN is defined.
module tb_regset_wr_arb;

  logic        clock;
  logic        reset;
  logic [2:0]  req;
  logic [8:0]  req_addr;
  logic [11:0] req_data;
`ifdef REGSET_ARB_LOCK_EN
  logic [2:0]  lock_v;
`endif
  logic [2:0]  gnt;
  logic [2:0]  WR;
  logic [3:0]  WRD;
  logic        Reg_EN;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] wr;
    logic [3:0] wrd;
    logic       en;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] m_wr  = '0;
  logic [3:0] m_wrd = '0;

  // Six-entry register set driven by the arbiter's write port.
  logic [3:0] rs [0:5];
  logic [2:0] ra, rb;

  regset_wr_arb #(
    .NREQ     (3),
    .NREGS    (6),
    .MAXBURST (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
`ifdef REGSET_ARB_LOCK_EN
    .lock     (lock_v),
`endif
    .gnt      (gnt),
    .WR       (WR),
    .WRD      (WRD),
    .Reg_EN   (Reg_EN),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (Reg_EN && WR < 3'd6) rs[WR] <= WRD;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive, check gnt mid-cycle, push the expected write-port
  // result, then pop and compare it just after the next rising edge.
  task automatic step(input string tag, input logic [2:0] r, input logic [8:0] a,
                      input logic [11:0] d, input logic [2:0] eg);
    exp_t       e;
    exp_t       o;
    int         idx;
    logic [2:0] addr;
    req      = r;
    req_addr = a;
    req_data = d;
    @(negedge clock);
    check({tag, "/gnt"}, 32'(gnt), 32'(eg));
    idx = 0;
    for (int i = 0; i < 3; i++) if (eg[i]) idx = i;
    if (reset) begin
      m_wr  = '0;
      m_wrd = '0;
      e     = '{wr: 3'd0, wrd: 4'd0, en: 1'b0, err: 1'b0};
    end else if (eg != 3'b000) begin
      addr = a[3*idx +: 3];
      if (addr < 3'd6) begin
        m_wr  = addr;
        m_wrd = d[4*idx +: 4];
        e     = '{wr: m_wr, wrd: m_wrd, en: 1'b1, err: 1'b0};
      end else begin
        e     = '{wr: m_wr, wrd: m_wrd, en: 1'b0, err: 1'b1};
      end
    end else begin
      e = '{wr: m_wr, wrd: m_wrd, en: 1'b0, err: 1'b0};
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    o = sb.pop_front();
    check({tag, "/WR"},     32'(WR),     32'(o.wr));
    check({tag, "/WRD"},    32'(WRD),    32'(o.wrd));
    check({tag, "/Reg_EN"}, 32'(Reg_EN), 32'(o.en));
    check({tag, "/err"},    32'(err),    32'(o.err));
  endtask

  localparam logic [8:0]  A_RR = {3'd3, 3'd2, 3'd1};
  localparam logic [11:0] D_RR = {4'd7, 4'd13, 4'd5};

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    ra       = 3'd1;
    rb       = 3'd2;
`ifdef REGSET_ARB_LOCK_EN
    lock_v   = '0;
`endif

    // Reset held two cycles with all requesters active.
    step("rst0", 3'b111, A_RR, D_RR, 3'b000);
    step("rst1", 3'b111, A_RR, D_RR, 3'b000);
    reset = 1'b0;

    // Round-robin from index 0, one accept per cycle.
    step("rr0", 3'b111, A_RR, D_RR, 3'b001);
    step("rr1", 3'b111, A_RR, D_RR, 3'b010);
    step("rr2", 3'b111, A_RR, D_RR, 3'b100);
    step("rr3", 3'b111, A_RR, D_RR, 3'b001);

    // Out-of-range index 6: err pulse, write port holds.
    step("range6", 3'b001, {3'd0, 3'd0, 3'd6}, {4'd0, 4'd0, 4'b1010}, 3'b001);
    check("readback_RA", 32'(rs[ra]), 32'(4'b0101));
    check("readback_RB", 32'(rs[rb]), 32'(4'b1101));

    step("idle", 3'b000, '0, '0, 3'b000);

    // Boundary indices 5 (last valid) and 7, alternating requesters.
    step("alt7", 3'b011, {3'd0, 3'd7, 3'd5}, {4'd0, 4'd9, 4'd4}, 3'b010);
    step("alt5", 3'b011, {3'd0, 3'd7, 3'd5}, {4'd0, 4'd9, 4'd4}, 3'b001);
    step("alt7b", 3'b011, {3'd0, 3'd7, 3'd5}, {4'd0, 4'd9, 4'd4}, 3'b010);

`ifdef REGSET_ARB_LOCK_EN
    // Park last_winner at 0 so requester 1 is next in line.
    step("pre0", 3'b001, {3'd0, 3'd0, 3'd1}, {4'd0, 4'd0, 4'd3}, 3'b001);

    // Full burst: four locked accepts to 1, then 0 gets its turn.
    lock_v = 3'b010;
    for (int i = 0; i < 4; i++)
      step($sformatf("burst%0d", i), 3'b011, {3'd0, 3'd2, 3'd4}, {4'd0, 4'd9, 4'd6}, 3'b010);
    step("burst_end", 3'b011, {3'd0, 3'd2, 3'd4}, {4'd0, 4'd9, 4'd6}, 3'b001);

    // Early release after two accepts.
    step("early0", 3'b011, {3'd0, 3'd3, 3'd4}, {4'd0, 4'd2, 4'd6}, 3'b010);
    step("early1", 3'b011, {3'd0, 3'd3, 3'd4}, {4'd0, 4'd2, 4'd6}, 3'b010);
    lock_v = 3'b000;
    step("early_drop", 3'b011, {3'd0, 3'd3, 3'd4}, {4'd0, 4'd2, 4'd6}, 3'b000);
    step("early_arb", 3'b011, {3'd0, 3'd3, 3'd4}, {4'd0, 4'd2, 4'd6}, 3'b001);

    // Reset in the middle of a burst.
    lock_v = 3'b010;
    step("mid0", 3'b011, {3'd0, 3'd1, 3'd2}, {4'd0, 4'd8, 4'd1}, 3'b010);
    step("mid1", 3'b011, {3'd0, 3'd1, 3'd2}, {4'd0, 4'd8, 4'd1}, 3'b010);
    reset = 1'b1;
    step("mid_rst", 3'b011, {3'd0, 3'd1, 3'd2}, {4'd0, 4'd8, 4'd1}, 3'b000);
    reset = 1'b0;
    step("post_rst", 3'b011, {3'd0, 3'd1, 3'd2}, {4'd0, 4'd8, 4'd1}, 3'b001);
    step("post_rst1", 3'b011, {3'd0, 3'd1, 3'd2}, {4'd0, 4'd8, 4'd1}, 3'b010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regset_wr_arb.md
REGSET_WR_ARB -- requirements
Module: regset_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of write requesters (2..4).
REQ-002 SHALL have parameter NREGS, default 6, number of implemented registers at the target register set.
REQ-003 SHALL have parameter MAXBURST, default 4, maximum consecutive locked accepts per requester.
REQ-004 SHALL have port clock, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port req, input, NREQ, per-requester write valid.
REQ-007 SHALL have port req_addr, input, NREQ*3, per-requester register index, requester i at bits [3i+2:3i].
REQ-008 SHALL have port req_data, input, NREQ*4, per-requester write data, requester i at bits [4i+3:4i].
REQ-009 SHALL have port gnt, output, NREQ, combinational accept; transfer occurs when req[i]&gnt[i].
REQ-010 SHALL have port WR, output, 3, registered register-set write index.
REQ-011 SHALL have port WRD, output, 4, registered register-set write data.
REQ-012 SHALL have port Reg_EN, output, 1, registered register-set write enable.
REQ-013 SHALL have port err, output, 1, registered one-cycle pulse for an accepted out-of-range address.

Function
REQ-014 SHALL assert at most one gnt bit per cycle, and none while reset is high.
REQ-015 SHALL grant in state ARB to the first requesting index after last_winner, wrapping NREQ-1 -> 0 (round-robin).
REQ-016 SHALL update last_winner to the accepted index on every accept.
REQ-017 SHALL, on accept, drive next cycle WR=req_addr[i], WRD=req_data[i], Reg_EN=1 when addr<NREGS (latency 1 cycle).
REQ-018 SHALL, on accept with addr>=NREGS, drive Reg_EN=0 and err=1 next cycle, holding WR/WRD unchanged.
REQ-019 SHALL drive Reg_EN=0 and err=0 in every cycle following a cycle with no accept.
REQ-020 SHALL sustain one accept per cycle (back-to-back writes from alternating requesters).
REQ-021 SHALL define states ARB and LOCK; ARB->LOCK when accepted requester has lock[i]=1 (config-dependent); LOCK->ARB when owner deasserts req or lock, or burst count reaches MAXBURST.
REQ-022 SHALL in LOCK grant only the owner; other requests wait without loss.
REQ-023 SHALL count accepts in a burst with a 3-bit counter reset on ARB->LOCK entry; the MAXBURST-th accept forces return to ARB with last_winner=owner.
REQ-024 SHALL treat requester index order as the only tie-break on first cycle after reset (last_winner=NREQ-1, so index 0 wins).

Reset
REQ-025 SHALL on reset set state=ARB, last_winner=NREQ-1, burst count=0, WR=0, WRD=0, Reg_EN=0, err=0.
REQ-026 SHALL abandon a burst in progress when reset asserts mid-LOCK; no write is issued in the cycle after reset.

Configuration
REQ-027 SHALL with macro REGSET_ARB_LOCK_EN defined add input lock, NREQ wide, and implement LOCK state per REQ-021..023.
REQ-028 SHALL without REGSET_ARB_LOCK_EN omit the lock port and LOCK state; arbitration is pure round-robin every cycle.

Structure
REQ-029 SHALL place state encoding (ARB, LOCK), register-index width 3, data width 4, and default NREGS=6 in shared package regset_pkg.
REQ-030 SHALL implement the round-robin priority pick as sub-module rr_pick (req vector + last_winner -> one-hot grant).

Verification
REQ-031 SHALL test reset: reset held 2 cycles with req=3'b111 -> gnt=0, Reg_EN=0, WR=0, WRD=0, err=0.
REQ-032 SHALL test round-robin: req=3'b111 held 4 cycles after reset -> gnt sequence 001,010,100,001; Reg_EN=1 each following cycle with matching WR/WRD.
REQ-033 SHALL test range check: single req0 addr=3'b110 data=4'b1010 -> gnt[0]=1, next cycle Reg_EN=0, err=1, WR/WRD unchanged.
REQ-034 SHALL test lock burst (REGSET_ARB_LOCK_EN): req1+lock1 held, req0 held -> req1 granted 4 consecutive cycles, then req0 granted on 5th.
REQ-035 SHALL test early release and mid-burst reset: lock1 dropped after 2 accepts -> ARB next cycle, req0 granted; reset during LOCK -> state ARB, index 0 wins first.
REQ-036 SHALL test end-to-end with regset6 instance: writes 5->reg1, 13->reg2 via two requesters -> readback RA=1 gives 0101, RB=2 gives 1101.
